vend_ctrl: RTL and testbench

VEND_CTRL -- requirements
Module: vend_ctrl

---
 rtl/vend_pkg.sv | 54 +++++
 rtl/change_picker.sv | 30 +++
 rtl/vend_ctrl.sv | 174 +++++++++++++++++
 tb/tb_vend_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared coin/product codes, their cent values, and the vending FSM state encoding.
package vend_pkg;

  localparam int unsigned VAL_W = 7;

  typedef enum logic [1:0] {
    COIN_NICKEL  = 2'b00,
    COIN_DIME    = 2'b01,
    COIN_QUARTER = 2'b10,
    COIN_DOLLAR  = 2'b11
  } coin_e;

  typedef enum logic [1:0] {
    ITEM_GUM     = 2'b00,
    ITEM_CANDY   = 2'b01,
    ITEM_COOKIES = 2'b10,
    ITEM_CHIPS   = 2'b11
  } item_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_VEND   = 2'b01,
    ST_CHANGE = 2'b10
  } state_e;

  localparam logic [VAL_W-1:0] VAL_NICKEL  = 7'd5;
  localparam logic [VAL_W-1:0] VAL_DIME    = 7'd10;
  localparam logic [VAL_W-1:0] VAL_QUARTER = 7'd25;
  localparam logic [VAL_W-1:0] VAL_DOLLAR  = 7'd100;

  localparam logic [VAL_W-1:0] PRICE_GUM     = 7'd50;
  localparam logic [VAL_W-1:0] PRICE_CANDY   = 7'd75;
  localparam logic [VAL_W-1:0] PRICE_COOKIES = 7'd65;
  localparam logic [VAL_W-1:0] PRICE_CHIPS   = 7'd85;

  function automatic logic [VAL_W-1:0] coin_value(input coin_e c);
    case (c)
      COIN_NICKEL:  coin_value = VAL_NICKEL;
      COIN_DIME:    coin_value = VAL_DIME;
      COIN_QUARTER: coin_value = VAL_QUARTER;
      default:      coin_value = VAL_DOLLAR;
    endcase
  endfunction

  function automatic logic [VAL_W-1:0] item_price(input item_e i);
    case (i)
      ITEM_GUM:     item_price = PRICE_GUM;
      ITEM_CANDY:   item_price = PRICE_CANDY;
      ITEM_COOKIES: item_price = PRICE_COOKIES;
      default:      item_price = PRICE_CHIPS;
    endcase
  endfunction

endpackage

// File: rtl/change_picker.sv
// Picks the largest of quarter/dime/nickel that does not exceed the remaining credit.
module change_picker
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] credit,
  output coin_e               coin_c,
  output logic [VAL_W-1:0]    value_c
);

  localparam int unsigned AW = (CREDIT_W > VAL_W) ? CREDIT_W : VAL_W;

  logic [AW-1:0] credit_ext;

  assign credit_ext = AW'(credit);

  always_comb begin
    coin_c  = COIN_NICKEL;
    value_c = VAL_NICKEL;
    if (credit_ext >= AW'(VAL_QUARTER)) begin
      coin_c  = COIN_QUARTER;
      value_c = VAL_QUARTER;
    end else if (credit_ext >= AW'(VAL_DIME)) begin
      coin_c  = COIN_DIME;
      value_c = VAL_DIME;
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending machine controller: credit accumulation, vend timing and coin change.
// Define VEND_CHANGE_EN to enable the CHANGE state (refund and change return).
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W    = 8,
  parameter int unsigned VEND_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                sel_valid,
  input  logic [1:0]          sel_item,
  input  logic                refund,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                sel_nack,
  output logic                dispense_valid,
  output logic [1:0]          dispense_item,
  output logic                change_valid,
  output logic [1:0]          change_type,
  output logic                busy
);

  // One spare bit above the wider of credit/value so sums never overflow.
  localparam int unsigned AW    = ((CREDIT_W > VAL_W) ? CREDIT_W : VAL_W) + 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [AW-1:0] CREDIT_MAX = {{(AW-CREDIT_W){1'b0}}, {CREDIT_W{1'b1}}};

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                coin_reject_q, coin_reject_d;
  logic                sel_nack_q, sel_nack_d;
  logic                dispense_valid_q, dispense_valid_d;
  logic [1:0]          dispense_item_q, dispense_item_d;
  logic                change_valid_q, change_valid_d;
  logic [1:0]          change_type_q, change_type_d;
  logic                busy_q, busy_d;

  logic [AW-1:0] credit_ext, coin_sum, price_ext;

  assign credit_ext = AW'(credit_q);
  assign coin_sum   = credit_ext + AW'(coin_value(coin_e'(coin_type)));
  assign price_ext  = AW'(item_price(item_e'(sel_item)));

`ifdef VEND_CHANGE_EN
  coin_e            pick_coin_c;
  logic [VAL_W-1:0] pick_value_c;

  change_picker #(.CREDIT_W(CREDIT_W)) u_change_picker (
    .credit  (credit_q),
    .coin_c  (pick_coin_c),
    .value_c (pick_value_c)
  );
`else
  logic unused_refund;
  assign unused_refund = refund;
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d          = state_q;
    credit_d         = credit_q;
    cnt_d            = cnt_q;
    coin_reject_d    = 1'b0;
    sel_nack_d       = 1'b0;
    dispense_valid_d = 1'b0;
    dispense_item_d  = dispense_item_q;
    change_valid_d   = 1'b0;
    change_type_d    = 2'b00;

    unique case (state_q)
      ST_IDLE: begin
        dispense_item_d = 2'b00;
        if (coin_valid) begin
          if (coin_sum <= CREDIT_MAX) begin
            credit_d = CREDIT_W'(coin_sum);
          end else begin
            coin_reject_d = 1'b1;
          end
          sel_nack_d = sel_valid;
        end else if (sel_valid) begin
          if (credit_ext >= price_ext) begin
            credit_d         = CREDIT_W'(credit_ext - price_ext);
            cnt_d            = CNT_W'(VEND_CYCLES - 1);
            dispense_valid_d = 1'b1;
            dispense_item_d  = sel_item;
            state_d          = ST_VEND;
          end else begin
            sel_nack_d = 1'b1;
          end
        end
`ifdef VEND_CHANGE_EN
        else if (refund && (credit_q != '0)) begin
          state_d = ST_CHANGE;
        end
`endif
      end

      ST_VEND: begin
        coin_reject_d = coin_valid;
        sel_nack_d    = sel_valid;
        if (cnt_q != '0) begin
          cnt_d            = cnt_q - CNT_W'(1);
          dispense_valid_d = 1'b1;
        end else begin
          dispense_item_d = 2'b00;
`ifdef VEND_CHANGE_EN
          state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end
      end

`ifdef VEND_CHANGE_EN
      ST_CHANGE: begin
        coin_reject_d  = coin_valid;
        sel_nack_d     = sel_valid;
        change_valid_d = 1'b1;
        change_type_d  = pick_coin_c;
        credit_d       = credit_q - CREDIT_W'(pick_value_c);
        if (credit_d == '0) begin
          state_d = ST_IDLE;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      credit_q         <= '0;
      cnt_q            <= '0;
      coin_reject_q    <= 1'b0;
      sel_nack_q       <= 1'b0;
      dispense_valid_q <= 1'b0;
      dispense_item_q  <= 2'b00;
      change_valid_q   <= 1'b0;
      change_type_q    <= 2'b00;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      credit_q         <= credit_d;
      cnt_q            <= cnt_d;
      coin_reject_q    <= coin_reject_d;
      sel_nack_q       <= sel_nack_d;
      dispense_valid_q <= dispense_valid_d;
      dispense_item_q  <= dispense_item_d;
      change_valid_q   <= change_valid_d;
      change_type_q    <= change_type_d;
      busy_q           <= busy_d;
    end
  end

  assign credit         = credit_q;
  assign coin_reject    = coin_reject_q;
  assign sel_nack       = sel_nack_q;
  assign dispense_valid = dispense_valid_q;
  assign dispense_item  = dispense_item_q;
  assign change_valid   = change_valid_q;
  assign change_type    = change_type_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: directed scenarios plus random strobes against
// a transaction-level model that scripts each vend/change sequence as a queue.
module tb_vend_ctrl;

  localparam int unsigned CREDIT_W    = 8;
  localparam int unsigned VEND_CYCLES = 4;
  localparam int          CMAX        = 255;
`ifdef VEND_CHANGE_EN
  localparam bit CHG = 1'b1;
`else
  localparam bit CHG = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                coin_valid = 1'b0;
  logic [1:0]          coin_type = 2'b00;
  logic                sel_valid = 1'b0;
  logic [1:0]          sel_item = 2'b00;
  logic                refund = 1'b0;
  logic [CREDIT_W-1:0] credit;
  logic                coin_reject, sel_nack, dispense_valid, change_valid, busy;
  logic [1:0]          dispense_item, change_type;

  vend_ctrl #(.CREDIT_W(CREDIT_W), .VEND_CYCLES(VEND_CYCLES)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .coin_valid     (coin_valid),
    .coin_type      (coin_type),
    .sel_valid      (sel_valid),
    .sel_item       (sel_item),
    .refund         (refund),
    .credit         (credit),
    .coin_reject    (coin_reject),
    .sel_nack       (sel_nack),
    .dispense_valid (dispense_valid),
    .dispense_item  (dispense_item),
    .change_valid   (change_valid),
    .change_type    (change_type),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Expected post-edge outputs for one cycle of a vend/change sequence.
  typedef struct {
    bit dv;
    int di;
    bit cv;
    int ct;
    int cr;
    bit bsy;
  } exp_t;

  exp_t script[$];
  int   m_credit;
  int   n_checks = 0;
  int   n_errors = 0;
  int   coin_val[4]  = '{5, 10, 25, 100};
  int   item_cost[4] = '{50, 75, 65, 85};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t mk(input bit dv, input int di, input bit cv, input int ct,
                              input int cr, input bit bsy);
    exp_t e;
    e.dv = dv; e.di = di; e.cv = cv; e.ct = ct; e.cr = cr; e.bsy = bsy;
    return e;
  endfunction

  // Greedy change: quarters, then dimes, then nickels; one coin per cycle.
  task automatic push_change(input int start);
    int c = start;
    while (c > 0) begin
      if (c >= 25) begin c -= 25; script.push_back(mk(0, 0, 1, 2, c, c != 0)); end
      else if (c >= 10) begin c -= 10; script.push_back(mk(0, 0, 1, 1, c, c != 0)); end
      else begin c -= 5; script.push_back(mk(0, 0, 1, 0, c, c != 0)); end
    end
  endtask

  task automatic tick(input bit cv, input int ct, input bit sv, input int si, input bit rf);
    exp_t e;
    bit   rej = 0;
    bit   nack = 0;
    coin_valid = cv;
    coin_type  = 2'(ct);
    sel_valid  = sv;
    sel_item   = 2'(si);
    refund     = rf;
    e = mk(0, 0, 0, 0, m_credit, 0);
    if (script.size() == 0) begin
      if (cv) begin
        if (m_credit + coin_val[ct] <= CMAX) m_credit += coin_val[ct];
        else rej = 1;
        nack = sv;
        e.cr = m_credit;
      end else if (sv) begin
        if (m_credit >= item_cost[si]) begin
          m_credit -= item_cost[si];
          for (int i = 0; i < int'(VEND_CYCLES); i++)
            script.push_back(mk(1, si, 0, 0, m_credit, 1));
          if (CHG && m_credit > 0) begin
            script.push_back(mk(0, 0, 0, 0, m_credit, 1));
            push_change(m_credit);
          end else begin
            script.push_back(mk(0, 0, 0, 0, m_credit, 0));
          end
          e = script.pop_front();
        end else begin
          nack = 1;
        end
      end else if (rf && CHG && m_credit > 0) begin
        script.push_back(mk(0, 0, 0, 0, m_credit, 1));
        push_change(m_credit);
        e = script.pop_front();
      end
    end else begin
      e    = script.pop_front();
      rej  = cv;
      nack = sv;
    end
    m_credit = e.cr;
    @(posedge clk);
    #1;
    check("credit", 32'(credit), 32'(e.cr));
    check("coin_reject", 32'(coin_reject), 32'(rej));
    check("sel_nack", 32'(sel_nack), 32'(nack));
    check("dispense_valid", 32'(dispense_valid), 32'(e.dv));
    check("dispense_item", 32'(dispense_item), 32'(e.di));
    check("change_valid", 32'(change_valid), 32'(e.cv));
    check("change_type", 32'(change_type), 32'(e.ct));
    check("busy", 32'(busy), 32'(e.bsy));
    coin_valid = 1'b0;
    sel_valid  = 1'b0;
    refund     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
  endtask

  // Asserts reset between edges and checks that outputs clear without waiting for a clock.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    script.delete();
    m_credit = 0;
    check("rst_credit", 32'(credit), 32'd0);
    check("rst_strobes", 32'({coin_reject, sel_nack, dispense_valid, change_valid}), 32'd0);
    check("rst_codes", 32'({dispense_item, change_type}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Quarter, quarter, dime accumulate.
    tick(1, 2, 0, 0, 0); check("acc_q1", 32'(credit), 32'd25);
    tick(1, 2, 0, 0, 0); check("acc_q2", 32'(credit), 32'd50);
    tick(1, 1, 0, 0, 0); check("acc_d", 32'(credit), 32'd60);

    // Candy at 60 cents is refused.
    tick(0, 0, 1, 1, 0);
    check("nack_candy", 32'(sel_nack), 32'd1);
    check("nack_busy", 32'(busy), 32'd0);
    tick(1, 2, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    check("acc_100", 32'(credit), 32'd100);

    // Chips from 100 cents.
    tick(0, 0, 1, 3, 0);
    check("chips_disp", 32'({dispense_valid, dispense_item}), 32'd7);
    idle(VEND_CYCLES + 6);
    check("chips_credit", 32'(credit), CHG ? 32'd0 : 32'd15);

    // Overflow rejection and coin-over-select priority.
    do_reset();
    tick(1, 3, 0, 0, 0);
    tick(1, 3, 0, 0, 0);
    tick(1, 3, 0, 0, 0);
    check("ovf_reject", 32'(coin_reject), 32'd1);
    check("ovf_credit", 32'(credit), 32'd200);
    tick(1, 0, 1, 0, 0);
    check("prio_credit", 32'(credit), 32'd205);
    check("prio_nack", 32'(sel_nack), 32'd1);

    // Refund of 40 cents.
    do_reset();
    tick(1, 2, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    idle(5);
    check("refund_credit", 32'(credit), CHG ? 32'd0 : 32'd40);

    // Reset during the second vend cycle aborts the sequence.
    do_reset();
    tick(1, 3, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0);
    #2;
    do_reset();
    idle(VEND_CYCLES + 6);

    // Gum from a dollar.
    tick(1, 3, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    idle(VEND_CYCLES + 6);
    check("gum_credit", 32'(credit), CHG ? 32'd0 : 32'd50);

    // Random strobes with occasional mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 99) < 35, int'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 25, int'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 15);
      if ($urandom_range(0, 299) == 0) begin
        #2;
        do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
